// File: rtl/shift64_sched.sv
// Scheduler sharing one 64-bit PISO event shifter between NREQ word sources.
// Define SHIFT64_SCHED_RR_EN for round-robin arbitration; fixed priority otherwise.
module shift64_sched #(
  parameter int unsigned NREQ = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NREQ-1:0]           req,
  input  logic [64*NREQ-1:0]        data,
  output logic [NREQ-1:0]           ack,
  output logic                      load,
  output logic [63:0]               pi,
  output logic                      frame,
  output logic [$clog2(NREQ)-1:0]   src,
  output logic                      busy
);

  localparam int unsigned SW = $clog2(NREQ);

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [SW-1:0] src_q, src_d;
  logic [SW-1:0] last_q, last_d;

  logic          win_valid;
  logic [SW-1:0] win;
  logic          last_bit;
  logic          grant;
  logic [63:0]   words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : gen_words
    assign words[g] = data[64*g +: 64];
  end

  // Arbiter; win is only meaningful when win_valid is set.
  always_comb begin
    win_valid = 1'b0;
    win       = last_q;
`ifdef SHIFT64_SCHED_RR_EN
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!win_valid && req[i] && (((32'(last_q) + k) % NREQ) == i)) begin
          win_valid = 1'b1;
          win       = SW'(i);
        end
      end
    end
`else
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!win_valid && req[i]) begin
        win_valid = 1'b1;
        win       = SW'(i);
      end
    end
`endif
  end

  assign last_bit = (state_q == StShift) && (cnt_q == 6'd63);

  // Gated by reset_n so a word held in reset is never acked.
  assign grant = reset_n && enable && win_valid && ((state_q == StIdle) || last_bit);

  always_comb begin
    ack = '0;
    if (grant) begin
      ack[win] = 1'b1;
    end
  end

  assign load  = grant;
  assign pi    = grant ? words[win] : 64'd0;
  assign frame = (state_q == StShift);
  assign src   = src_q;
  assign busy  = frame | load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        cnt_d = 6'd0;
      end
      StShift: begin
        if (last_bit) begin
          cnt_d   = 6'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 6'd0;
      end
    endcase
    // A grant on the last bit reloads so the next word follows with no gap.
    if (grant) begin
      state_d = StShift;
      cnt_d   = 6'd0;
      src_d   = win;
      last_d  = win;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      src_q   <= '0;
      last_q  <= SW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

`ifndef SYNTHESIS
  ack_onehot_a: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(ack));
  last_range_a: assert property (@(posedge clk) disable iff (!reset_n) 32'(last_q) < NREQ);
  idle_cnt_a:   assert property (@(posedge clk) disable iff (!reset_n)
                                 (state_q == StIdle) |-> (cnt_q == 6'd0));
`endif

endmodule
